// File: rtl/rv32i_step_sequencer_pkg.sv
// Shared types and opcode helpers for the RV32I multi-cycle step sequencer.
package rv32i_seq_pkg;

    localparam logic [6:0] OP_OPPI   = 7'b0010011;
    localparam logic [6:0] OP_OPPR   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } seq_state_t;

    // Decoder/branch flags captured at the end of EXEC for use in MEM and WB.
    typedef struct packed {
        logic reg_write;
        logic ram_write;
        logic test_branch;
        logic always_branch;
        logic branch_taken;
    } exec_flags_t;

    function automatic logic opcode_is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_OPPI, OP_OPPR, OP_LUI, OP_AUIPC, OP_JAL,
            OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rv32i_step_sequencer_mem_watchdog.sv
// Memory-stall watchdog: counts unacknowledged request cycles and flags the
// cycle on which the wait would reach MEM_TIMEOUT.
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear || (MEM_TIMEOUT == 0)) begin
            count_reg <= '0;
        end else if (count_en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Fires while the limit-th waiting cycle is in progress, so an ack in that
    // same cycle still takes priority in the FSM.
    assign expired = (MEM_TIMEOUT != 0) && count_en && (count_reg == LAST_WAIT);

endmodule

// File: rtl/rv32i_step_sequencer.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute, memory,
// writeback over a single req/ack memory port, with stall watchdog and retire count.
module rv32i_step_sequencer
    import rv32i_seq_pkg::*;
#(
    parameter int dataW       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             RegWriteControl,
    input  logic             LinkAddrWrite,
    input  logic             TestBranch,
    input  logic             AlwaysBranch,
    input  logic             RAMWriteControl,
    input  logic             RAMRegRead,
    input  logic             branchTaken,
    input  logic             memAck,
    output logic             memReq,
    output logic             memWrite,
    output logic             memAddrSel,
    output logic             insLoad,
    output logic             RegWriteEn,
    output logic             PCWriteEn,
    output logic             PCBranch,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [dataW-1:0] retired,
    output logic [2:0]       state
);
    seq_state_t       state_reg, state_next;
    exec_flags_t      flags_reg, flags_live, flags_eff;
    logic             mem_req_reg, mem_write_reg, mem_addr_sel_reg;
    logic             reg_write_en_reg, pc_write_en_reg, pc_branch_reg;
    logic             halted_reg, illegal_reg, timeout_reg;
    logic [dataW-1:0] retired_reg;
    logic             wd_expired;
    logic             unused_link;

    // Link-address selection only steers the writeback mux outside this block.
    assign unused_link = LinkAddrWrite;

    mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (~mem_req_reg),
        .count_en (mem_req_reg & ~memAck),
        .expired  (wd_expired)
    );

    assign flags_live = '{
        reg_write:     RegWriteControl,
        ram_write:     RAMWriteControl,
        test_branch:   TestBranch,
        always_branch: AlwaysBranch,
        branch_taken:  branchTaken
    };
    // Leaving EXEC the flags are not yet latched, so use the live decoder values.
    assign flags_eff = (state_reg == ST_EXEC) ? flags_live : flags_reg;

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:   state_next = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_next = memAck ? ST_DECODE : (wd_expired ? ST_TRAP : ST_FETCH);
            ST_DECODE: state_next = opcode_is_legal(opcode) ? ST_EXEC : ST_TRAP;
            ST_EXEC:   state_next = RAMRegRead ? ST_MEM : ST_WB;
            ST_MEM:    state_next = memAck ? ST_WB : (wd_expired ? ST_TRAP : ST_MEM);
            ST_WB:     state_next = run ? ST_FETCH : ST_IDLE;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are clean Moore signals.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            flags_reg        <= '0;
            mem_req_reg      <= 1'b0;
            mem_write_reg    <= 1'b0;
            mem_addr_sel_reg <= 1'b0;
            reg_write_en_reg <= 1'b0;
            pc_write_en_reg  <= 1'b0;
            pc_branch_reg    <= 1'b0;
            halted_reg       <= 1'b0;
            illegal_reg      <= 1'b0;
            timeout_reg      <= 1'b0;
            retired_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            if (state_reg == ST_EXEC) begin
                flags_reg <= flags_live;
            end
            mem_req_reg      <= (state_next == ST_FETCH) || (state_next == ST_MEM);
            mem_addr_sel_reg <= (state_next == ST_MEM);
            mem_write_reg    <= (state_next == ST_MEM) && flags_eff.ram_write;
            reg_write_en_reg <= (state_next == ST_WB) && flags_eff.reg_write;
            pc_write_en_reg  <= (state_next == ST_WB);
            pc_branch_reg    <= (state_next == ST_WB) &&
                                (flags_eff.always_branch ||
                                 (flags_eff.test_branch && flags_eff.branch_taken));
            halted_reg       <= (state_next == ST_TRAP);
            if ((state_reg == ST_DECODE) && !opcode_is_legal(opcode)) begin
                illegal_reg <= 1'b1;
            end
            if (((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && wd_expired && !memAck) begin
                timeout_reg <= 1'b1;
            end
            if (state_reg == ST_WB) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    // Instruction register must capture the data on the acknowledging cycle.
    assign insLoad    = (state_reg == ST_FETCH) && memAck;
    assign memReq     = mem_req_reg;
    assign memWrite   = mem_write_reg;
    assign memAddrSel = mem_addr_sel_reg;
    assign RegWriteEn = reg_write_en_reg;
    assign PCWriteEn  = pc_write_en_reg;
    assign PCBranch   = pc_branch_reg;
    assign halted     = halted_reg;
    assign illegal    = illegal_reg;
    assign timeout    = timeout_reg;
    assign retired    = retired_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_rv32i_step_sequencer.sv
// Randomized bench: builds the expected per-cycle trace of each instruction from
// the sequencing rules and compares the sequencer outputs against it every cycle.
module tb_rv32i_step_sequencer;
    localparam int TO = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
    localparam logic [6:0] C_OPPI = 7'h13, C_OPPR = 7'h33, C_LUI = 7'h37, C_AUIPC = 7'h17,
                           C_JAL = 7'h6F, C_JALR = 7'h67, C_BRANCH = 7'h63, C_LOAD = 7'h03,
                           C_STORE = 7'h23;

    logic       clk = 1'b0;
    logic       reset, run, memAck;
    logic [6:0] opcode;
    logic       RegWriteControl, LinkAddrWrite, TestBranch, AlwaysBranch;
    logic       RAMWriteControl, RAMRegRead, branchTaken;
    logic       memReq, memWrite, memAddrSel, insLoad, RegWriteEn, PCWriteEn, PCBranch;
    logic       halted, illegal, timeout;
    logic [7:0] retired;
    logic [2:0] state;

    always #5 clk = ~clk;

    rv32i_step_sequencer #(.dataW(8), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .RegWriteControl(RegWriteControl), .LinkAddrWrite(LinkAddrWrite),
        .TestBranch(TestBranch), .AlwaysBranch(AlwaysBranch),
        .RAMWriteControl(RAMWriteControl), .RAMRegRead(RAMRegRead),
        .branchTaken(branchTaken), .memAck(memAck),
        .memReq(memReq), .memWrite(memWrite), .memAddrSel(memAddrSel), .insLoad(insLoad),
        .RegWriteEn(RegWriteEn), .PCWriteEn(PCWriteEn), .PCBranch(PCBranch),
        .halted(halted), .illegal(illegal), .timeout(timeout),
        .retired(retired), .state(state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic req, wr, sel, ins, rwe, pcwe, pcb, halt, ill, tmo;
        logic ack, run_in, rst_after, tx_end;
    } tb_cycle_t;

    tb_cycle_t  trace[$];
    int         checks_count = 0;
    int         fail_count   = 0;
    int         cycle_no     = 0;
    logic [7:0] exp_retired  = 8'd0;
    logic [6:0] legal_ops[9] = '{C_OPPI, C_OPPR, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE};

    wire [12:0] dut_vec = {state, memReq, memWrite, memAddrSel, insLoad, RegWriteEn,
                           PCWriteEn, PCBranch, halted, illegal, timeout};

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] exp_vec(input tb_cycle_t e);
        return {e.st, e.req, e.wr, e.sel, e.ins, e.rwe, e.pcwe, e.pcb, e.halt, e.ill, e.tmo};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Stray acks and run toggles outside the memory/decision points must be ignored.
    function automatic tb_cycle_t blank_cycle(input logic [2:0] st);
        tb_cycle_t e;
        e = '0;
        e.st     = st;
        e.run_in = 1'($urandom_range(0, 1));
        e.ack    = ($urandom_range(0, 3) == 0);
        return e;
    endfunction

    task automatic push_idle_go();
        tb_cycle_t e;
        e = blank_cycle(S_IDLE);
        e.run_in = 1'b1;
        trace.push_back(e);
    endtask

    task automatic add_trap(input bit ill, input bit tmo);
        tb_cycle_t e;
        for (int i = 0; i < 3; i++) begin
            e = blank_cycle(S_TRAP);
            e.halt = 1'b1; e.ill = ill; e.tmo = tmo;
            e.rst_after = (i == 2);
            e.tx_end    = (i == 2);
            trace.push_back(e);
        end
        push_idle_go();
    endtask

    // A request phase acked after d waiting cycles; d >= TO means the watchdog wins.
    task automatic add_wait(input logic [2:0] st, input bit data, input bit wr, input int d,
                            output bit trapped);
        tb_cycle_t e;
        int n;
        n = (d < TO) ? d + 1 : TO;
        for (int i = 0; i < n; i++) begin
            e = blank_cycle(st);
            e.req = 1'b1; e.sel = data; e.wr = wr;
            e.ack = (i == d);
            e.ins = !data && (i == d);
            trace.push_back(e);
        end
        trapped = (d >= TO);
    endtask

    task automatic set_decode(input logic [6:0] op, input bit taken);
        opcode          = op;
        RegWriteControl = (op == C_OPPI) || (op == C_OPPR) || (op == C_LUI) || (op == C_AUIPC) ||
                          (op == C_JAL) || (op == C_JALR) || (op == C_LOAD);
        LinkAddrWrite   = (op == C_JAL) || (op == C_JALR);
        AlwaysBranch    = (op == C_JAL) || (op == C_JALR);
        TestBranch      = (op == C_BRANCH);
        RAMWriteControl = (op == C_STORE);
        RAMRegRead      = (op == C_LOAD) || (op == C_STORE);
        branchTaken     = taken;
    endtask

    task automatic build_instr(input logic [6:0] op, input int fd, input int dd,
                               input bit stop, input bit taken);
        tb_cycle_t e;
        bit t;
        set_decode(op, taken);
        add_wait(S_FETCH, 1'b0, 1'b0, fd, t);
        if (t) begin add_trap(1'b0, 1'b1); return; end
        trace.push_back(blank_cycle(S_DECODE));
        if (!is_legal(op)) begin add_trap(1'b1, 1'b0); return; end
        trace.push_back(blank_cycle(S_EXEC));
        if (RAMRegRead) begin
            add_wait(S_MEM, 1'b1, RAMWriteControl, dd, t);
            if (t) begin add_trap(1'b0, 1'b1); return; end
        end
        e = blank_cycle(S_WB);
        e.rwe = RegWriteControl; e.pcwe = 1'b1;
        e.pcb = AlwaysBranch || (TestBranch && taken);
        e.run_in = !stop; e.tx_end = 1'b1;
        trace.push_back(e);
        if (stop) push_idle_go();
    endtask

    task automatic build_reset_mid_mem();
        tb_cycle_t e;
        bit t;
        set_decode(C_LOAD, 1'b0);
        add_wait(S_FETCH, 1'b0, 1'b0, 0, t);
        trace.push_back(blank_cycle(S_DECODE));
        trace.push_back(blank_cycle(S_EXEC));
        e = blank_cycle(S_MEM);
        e.req = 1'b1; e.sel = 1'b1; e.ack = 1'b0;
        e.rst_after = 1'b1; e.tx_end = 1'b1;
        trace.push_back(e);
        push_idle_go();
    endtask

    task automatic run_trace();
        tb_cycle_t e;
        while (trace.size() > 0) begin
            e = trace.pop_front();
            @(posedge clk);
            #1;
            memAck = e.ack;
            run    = e.run_in;
            @(negedge clk);
            cycle_no++;
            check_value($sformatf("ctrl@c%0d", cycle_no), 64'(dut_vec), 64'(exp_vec(e)));
            check_value($sformatf("retired@c%0d", cycle_no), 64'(retired), 64'(exp_retired));
            if (e.st == S_WB) exp_retired = exp_retired + 8'd1;
            if (e.tx_end)
                $display("tx op=0x%02h end_state=%0d halted=%0d illegal=%0d timeout=%0d retired=%0d",
                         opcode, state, halted, illegal, timeout, retired);
            if (e.rst_after) begin
                reset = 1'b1; run = 1'b0; memAck = 1'b0;
                #1;
                check_value("reset_ctrl", 64'(dut_vec), 64'd0);
                check_value("reset_retired", 64'(retired), 64'd0);
                #1 reset = 1'b0;
                exp_retired = 8'd0;
            end
        end
    endtask

    function automatic int rand_wait(input int trap_odds);
        if (trap_odds > 0 && $urandom_range(0, trap_odds - 1) == 0) return TO + 2;
        return int'($urandom_range(0, TO - 1));
    endfunction

    initial begin
        logic [6:0] op;
        reset = 1'b1; run = 1'b0; memAck = 1'b0;
        set_decode(7'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("reset_ctrl_init", 64'(dut_vec), 64'd0);
        check_value("reset_retired_init", 64'(retired), 64'd0);
        #1 reset = 1'b0;

        trace.push_back(blank_cycle(S_IDLE));
        trace[0].run_in = 1'b0;
        push_idle_go();
        run_trace();

        build_instr(C_OPPI,   1, 0, 0, 0); run_trace();   // ADDI x1,x0,5
        build_instr(C_LOAD,   1, 3, 0, 0); run_trace();
        build_instr(C_STORE,  1, 3, 0, 0); run_trace();
        build_instr(C_BRANCH, 0, 0, 0, 1); run_trace();
        build_instr(C_BRANCH, 0, 0, 1, 0); run_trace();
        build_instr(C_JAL,    2, 0, 0, 0); run_trace();
        build_reset_mid_mem();             run_trace();
        build_instr(7'h73,    0, 0, 0, 0); run_trace();   // SYSTEM -> illegal trap
        build_instr(C_OPPR,   3, 0, 0, 0); run_trace();   // ack on the limit cycle
        build_instr(C_OPPR,   9, 0, 0, 0); run_trace();   // fetch watchdog
        build_instr(C_LOAD,   0, 9, 0, 0); run_trace();   // data watchdog

        // Long trap-free run so the retired counter wraps.
        for (int i = 0; i < 300; i++) begin
            build_instr(legal_ops[$urandom_range(0, 8)], rand_wait(0), rand_wait(0),
                        ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
            run_trace();
        end

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                do op = 7'($urandom_range(0, 127)); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            build_instr(op, rand_wait(20), rand_wait(20),
                        ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
            run_trace();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_count, fail_count);
        $finish;
    end

endmodule
